pointer_bank: RTL and testbench
===============================

Name: pointer_bank

Overview:
- Parametrised bank of NPTR pointer registers, each WIDTH bits.
- Any register can be designated instruction pointer (IP) via ip_sel, and any register data pointer (DP) via dp_sel.
- Drives a WIDTH-bit address bus from IP or DP and exposes DP byte-wise on an 8-bit data bus.
- Adds staged atomic multi-byte DP writes, a DP post-increment mode and a pending-write status; sits between the control unit and the memory address bus.

Parameters:
- NPTR, 4, number of pointer registers; must be >= 2.
- WIDTH, 16, pointer width in bits; must be a multiple of 8 and >= 16.
- RESET_VAL, 0, value loaded into every pointer on reset.
- Derived, not overridable: BYTES = WIDTH/8; SW = max(1, clog2(NPTR)); BW = max(1, clog2(BYTES)).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- di  in  8  data byte to write.
- byte_sel  in  BW  byte index for read/write; 0 = least significant.
- ip_sel  in  SW  index of the IP register.
- dp_sel  in  SW  index of the DP register.
- addr_dp  in  1  0: addr_out = IP; 1: addr_out = DP.
- n_oe_d  in  1  active-low data read enable.
- n_we  in  1  active-low byte write to DP.
- cnt  in  1  increment IP this cycle.
- cnt_dp  in  1  increment DP this cycle.
- addr_out  out  WIDTH  selected pointer value.
- data_out  out  8  selected DP byte; 0 when n_oe_d = 1.
- wr_pending  out  1  staging holds uncommitted bytes.

Behaviour:
- Reset, sampled on the clk edge with rst = 1:
  - all pointers <= RESET_VAL; staging register <= 0; wr_pending <= 0.
  - rst overrides every other input in that cycle, including a write or count in progress.
- addr_out is combinational: ptr[ip_sel] when addr_dp = 0, ptr[dp_sel] when addr_dp = 1.
  - Reflects committed state only; staging is never visible on addr_out.
  - Value after reset is RESET_VAL.
- data_out is combinational: byte byte_sel of ptr[dp_sel] when n_oe_d = 0, else 8'h00.
  - Reads return committed state, not staging.
  - byte_sel >= BYTES reads 8'h00.
- Write path, on a clk edge with n_we = 0:
  - byte_sel < BYTES-1: stage[byte_sel] <= di; wr_pending <= 1; pointers unchanged.
  - byte_sel = BYTES-1 (top byte): ptr[dp_sel] <= {di, stage[BYTES-2:0]}; staging cleared; wr_pending <= 0. The new value is visible on outputs in the next cycle.
  - Bytes never staged since the last commit or reset contribute 0.
  - byte_sel >= BYTES: ignored.
- Count:
  - cnt = 1: ptr[ip_sel] <= ptr[ip_sel] + 1, modulo 2^WIDTH; all-ones wraps to 0.
  - cnt_dp = 1: ptr[dp_sel] <= ptr[dp_sel] + 1, same wrap rule.
- Simultaneous events in one cycle, priority highest first:
  - rst.
  - Top-byte commit: if the commit target equals the IP or DP register being counted, the commit wins and that increment is dropped.
  - Increments.
  - If ip_sel = dp_sel and cnt = cnt_dp = 1, the register increments by exactly 1, not 2.
  - A staging write in the same cycle as a count does not block the count.
- Selector changes:
  - ip_sel/dp_sel may change on any cycle; they take effect combinationally on outputs and on the next edge for writes and counts.
  - Staging is not bound to dp_sel; the commit goes to the dp_sel value present at the commit edge.
- ip_sel = dp_sel is legal. The same register then serves both roles and addr_dp has no visible effect.
- Latency: writes and counts take 1 cycle (visible after the edge); reads take 0 cycles.
- No internal state other than the NPTR pointers, the (BYTES-1)-byte staging register and wr_pending.

Test Plan:
- Reset: pulse rst = 1 for 1 cycle, then read all pointers via addr_dp/dp_sel sweep -> every value 16'h0000; wr_pending = 0.
- Atomic write, WIDTH = 16, dp_sel = 2:
  - Write 8'h34 at byte 0 -> wr_pending = 1; addr_out (addr_dp = 1) still 16'h0000.
  - Write 8'h12 at byte 1 -> next cycle addr_out = 16'h1234; wr_pending = 0; data_out with byte_sel = 0 reads 8'h34.
- IP count with wrap: load ptr[0] = 16'hFFFE, ip_sel = 0, cnt = 1 for 3 cycles -> addr_out = 16'hFFFF, 16'h0000, 16'h0001.
- Conflict: ptr[1] = 16'h00FF; ip_sel = dp_sel = 1; cnt = 1 and cnt_dp = 1 in the same cycle as a top-byte write of 8'hAB with staged 8'hCD -> ptr[1] = 16'hABCD, no increment applied. Repeat without the write -> 16'hABCE.
- Reset mid-write: stage byte 0 = 8'h55, assert rst, then commit top byte 8'h66 -> ptr[dp_sel] = 16'h6600.
- Parametrised WIDTH = 24, NPTR = 8, dp_sel = 7:
  - Write bytes 8'h01, 8'h02, 8'h03 at byte_sel 0, 1, 2 -> addr_out = 24'h030201; other pointers unchanged.
  - byte_sel = 3 write -> ignored.

Source files
------------

// File: rtl/pointer_bank_if.sv
// Pointer bank bus: control-unit side (master) drives selectors, data and
// strobes; the pointer bank (slave) returns the address, read byte and status.
interface pointer_bank_if #(
  parameter int NPTR  = 4,
  parameter int WIDTH = 16
);
  localparam int BYTES = WIDTH / 8;
  localparam int SW    = (NPTR  > 2) ? $clog2(NPTR)  : 1;
  localparam int BW    = (BYTES > 2) ? $clog2(BYTES) : 1;

  logic [7:0]       di;
  logic [BW-1:0]    byte_sel;
  logic [SW-1:0]    ip_sel;
  logic [SW-1:0]    dp_sel;
  logic             addr_dp;
  logic             n_oe_d;
  logic             n_we;
  logic             cnt;
  logic             cnt_dp;
  logic [WIDTH-1:0] addr_out;
  logic [7:0]       data_out;
  logic             wr_pending;

  modport master (
    output di, byte_sel, ip_sel, dp_sel, addr_dp, n_oe_d, n_we, cnt, cnt_dp,
    input  addr_out, data_out, wr_pending
  );

  modport slave (
    input  di, byte_sel, ip_sel, dp_sel, addr_dp, n_oe_d, n_we, cnt, cnt_dp,
    output addr_out, data_out, wr_pending
  );
endinterface

// File: rtl/pointer_bank.sv
// Bank of NPTR pointer registers with selectable IP/DP roles, an address bus
// driven from IP or DP, byte-wise DP reads, staged atomic multi-byte DP
// writes (the top byte commits), and IP/DP post-increment.
module pointer_bank #(
  parameter int               NPTR      = 4,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  pointer_bank_if.slave pb
);
  localparam int BYTES = WIDTH / 8;

  logic [WIDTH-1:0]      ptr_q [NPTR];
  logic [WIDTH-1:0]      ptr_d [NPTR];
  logic [BYTES-2:0][7:0] stage_q;
  logic [BYTES-2:0][7:0] stage_d;
  logic                  pend_q;
  logic                  pend_d;

  logic                  top_byte_s;
  logic [WIDTH-1:0]      dp_val_s;
  logic [7:0]            data_s;

  assign top_byte_s = (int'(pb.byte_sel) == (BYTES - 1));
  assign dp_val_s   = ptr_q[pb.dp_sel];

  // Next state: increments first, staging writes next, a top-byte commit last
  // so it overrides any increment aimed at the same register. When IP and DP
  // are the same register both increments compute the same +1 value.
  always_comb begin
    ptr_d   = ptr_q;
    stage_d = stage_q;
    pend_d  = pend_q;
    if (pb.cnt) begin
      ptr_d[pb.ip_sel] = ptr_q[pb.ip_sel] + WIDTH'(1);
    end else begin
      ptr_d[pb.ip_sel] = ptr_q[pb.ip_sel];
    end
    if (pb.cnt_dp) begin
      ptr_d[pb.dp_sel] = ptr_q[pb.dp_sel] + WIDTH'(1);
    end
    if (!pb.n_we) begin
      if (top_byte_s) begin
        ptr_d[pb.dp_sel] = {pb.di, stage_q};
        stage_d          = '0;
        pend_d           = 1'b0;
      end else begin
        // Out-of-range byte indices match no slot and are ignored.
        for (int b = 0; b < BYTES - 1; b++) begin
          if (int'(pb.byte_sel) == b) begin
            stage_d[b] = pb.di;
            pend_d     = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPTR; i++) begin
        ptr_q[i] <= RESET_VAL;
      end
      stage_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
    end
  end

  // Byte read of the committed DP value; zero when disabled or out of range.
  always_comb begin
    data_s = 8'h00;
    if (!pb.n_oe_d) begin
      for (int b = 0; b < BYTES; b++) begin
        if (int'(pb.byte_sel) == b) begin
          data_s = dp_val_s[b*8 +: 8];
        end
      end
    end else begin
      data_s = 8'h00;
    end
  end

  assign pb.addr_out   = pb.addr_dp ? dp_val_s : ptr_q[pb.ip_sel];
  assign pb.data_out   = data_s;
  assign pb.wr_pending = pend_q;
endmodule

// File: tb/tb_pointer_bank.sv
// Directed self-checking bench for pointer_bank: a 16-bit/4-pointer instance
// and a 24-bit/8-pointer instance share clock and reset.
module tb_pointer_bank;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pointer_bank_if #(.NPTR(4), .WIDTH(16)) bus16 ();
  pointer_bank_if #(.NPTR(8), .WIDTH(24)) bus24 ();

  pointer_bank #(.NPTR(4), .WIDTH(16), .RESET_VAL(16'h0000)) u_pb16 (
    .clk (clk),
    .rst (rst),
    .pb  (bus16)
  );

  pointer_bank #(.NPTR(8), .WIDTH(24), .RESET_VAL(24'h000000)) u_pb24 (
    .clk (clk),
    .rst (rst),
    .pb  (bus24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write16(input logic [1:0] sel, input logic [15:0] val);
    bus16.dp_sel   = sel;
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b0;
    bus16.di       = val[7:0];
    tick();
    bus16.byte_sel = 1'b1;
    bus16.di       = val[15:8];
    tick();
    bus16.n_we     = 1'b1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus16.cnt  = 1'b1;
    bus16.n_we = 1'b0;
    tick();
    rst        = 1'b0;
    bus16.cnt  = 1'b0;
    bus16.n_we = 1'b1;
    bus16.addr_dp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus16.dp_sel = 2'(i);
      #1;
      checks++;
      if (bus16.addr_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_ptr16[%0d] got %h want 0000", i, bus16.addr_out);
      end
    end
    bus24.addr_dp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus24.dp_sel = 3'(i);
      #1;
      checks++;
      if (bus24.addr_out !== 24'h000000) begin
        errors++;
        $display("FAIL reset_ptr24[%0d] got %h want 000000", i, bus24.addr_out);
      end
    end
    checks++;
    if (bus16.wr_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending got %b want 0", bus16.wr_pending);
    end
    checks++;
    if (bus16.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_oe_off got %h want 00", bus16.data_out);
    end
  endtask

  task automatic test_atomic_write();
    bus16.dp_sel   = 2'd2;
    bus16.addr_dp  = 1'b1;
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b0;
    bus16.di       = 8'h34;
    tick();
    bus16.n_we = 1'b1;
    #1;
    checks++;
    if (bus16.wr_pending !== 1'b1) begin
      errors++;
      $display("FAIL stage_pending got %b want 1", bus16.wr_pending);
    end
    checks++;
    if (bus16.addr_out !== 16'h0000) begin
      errors++;
      $display("FAIL stage_invisible got %h want 0000", bus16.addr_out);
    end
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b1;
    bus16.di       = 8'h12;
    tick();
    bus16.n_we     = 1'b1;
    bus16.n_oe_d   = 1'b0;
    bus16.byte_sel = 1'b0;
    #1;
    checks++;
    if (bus16.addr_out !== 16'h1234) begin
      errors++;
      $display("FAIL commit_addr got %h want 1234", bus16.addr_out);
    end
    checks++;
    if (bus16.wr_pending !== 1'b0) begin
      errors++;
      $display("FAIL commit_pending got %b want 0", bus16.wr_pending);
    end
    checks++;
    if (bus16.data_out !== 8'h34) begin
      errors++;
      $display("FAIL read_byte0 got %h want 34", bus16.data_out);
    end
    bus16.byte_sel = 1'b1;
    #1;
    checks++;
    if (bus16.data_out !== 8'h12) begin
      errors++;
      $display("FAIL read_byte1 got %h want 12", bus16.data_out);
    end
    bus16.n_oe_d = 1'b1;
    #1;
    checks++;
    if (bus16.data_out !== 8'h00) begin
      errors++;
      $display("FAIL read_oe_off got %h want 00", bus16.data_out);
    end
  endtask

  task automatic test_ip_wrap();
    logic [15:0] exp [3];
    exp[0] = 16'hFFFF;
    exp[1] = 16'h0000;
    exp[2] = 16'h0001;
    write16(2'd0, 16'hFFFE);
    bus16.ip_sel  = 2'd0;
    bus16.addr_dp = 1'b0;
    bus16.cnt     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus16.addr_out !== exp[i]) begin
        errors++;
        $display("FAIL ip_wrap[%0d] got %h want %h", i, bus16.addr_out, exp[i]);
      end
    end
    bus16.cnt = 1'b0;
  endtask

  task automatic test_conflict();
    write16(2'd1, 16'h00FF);
    bus16.ip_sel   = 2'd1;
    bus16.dp_sel   = 2'd1;
    bus16.addr_dp  = 1'b1;
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b0;
    bus16.di       = 8'hCD;
    tick();
    checks++;
    if (bus16.addr_out !== 16'h00FF) begin
      errors++;
      $display("FAIL conflict_staged got %h want 00FF", bus16.addr_out);
    end
    bus16.byte_sel = 1'b1;
    bus16.di       = 8'hAB;
    bus16.cnt      = 1'b1;
    bus16.cnt_dp   = 1'b1;
    tick();
    bus16.n_we   = 1'b1;
    bus16.cnt    = 1'b0;
    bus16.cnt_dp = 1'b0;
    #1;
    checks++;
    if (bus16.addr_out !== 16'hABCD) begin
      errors++;
      $display("FAIL conflict_commit_wins got %h want ABCD", bus16.addr_out);
    end
    bus16.cnt    = 1'b1;
    bus16.cnt_dp = 1'b1;
    tick();
    bus16.cnt    = 1'b0;
    bus16.cnt_dp = 1'b0;
    checks++;
    if (bus16.addr_out !== 16'hABCE) begin
      errors++;
      $display("FAIL dual_inc_once got %h want ABCE", bus16.addr_out);
    end
    bus16.addr_dp = 1'b0;
    #1;
    checks++;
    if (bus16.addr_out !== 16'hABCE) begin
      errors++;
      $display("FAIL shared_reg_ip_view got %h want ABCE", bus16.addr_out);
    end
  endtask

  task automatic test_stage_with_count();
    // ptr[0] holds 0001 from the wrap test.
    bus16.ip_sel   = 2'd0;
    bus16.dp_sel   = 2'd3;
    bus16.addr_dp  = 1'b0;
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b0;
    bus16.di       = 8'h77;
    bus16.cnt      = 1'b1;
    tick();
    checks++;
    if (bus16.addr_out !== 16'h0002) begin
      errors++;
      $display("FAIL count_during_stage got %h want 0002", bus16.addr_out);
    end
    bus16.byte_sel = 1'b1;
    bus16.di       = 8'h88;
    tick();
    bus16.n_we = 1'b1;
    bus16.cnt  = 1'b0;
    #1;
    checks++;
    if (bus16.addr_out !== 16'h0003) begin
      errors++;
      $display("FAIL count_during_commit got %h want 0003", bus16.addr_out);
    end
    bus16.addr_dp = 1'b1;
    #1;
    checks++;
    if (bus16.addr_out !== 16'h8877) begin
      errors++;
      $display("FAIL commit_other_reg got %h want 8877", bus16.addr_out);
    end
  endtask

  task automatic test_reset_mid_write();
    bus16.dp_sel   = 2'd2;
    bus16.ip_sel   = 2'd0;
    bus16.addr_dp  = 1'b1;
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b0;
    bus16.di       = 8'h55;
    tick();
    rst            = 1'b1;
    bus16.byte_sel = 1'b1;
    bus16.di       = 8'h99;
    bus16.cnt      = 1'b1;
    tick();
    rst        = 1'b0;
    bus16.n_we = 1'b1;
    bus16.cnt  = 1'b0;
    #1;
    checks++;
    if (bus16.addr_out !== 16'h0000) begin
      errors++;
      $display("FAIL rst_overrides_commit got %h want 0000", bus16.addr_out);
    end
    checks++;
    if (bus16.wr_pending !== 1'b0) begin
      errors++;
      $display("FAIL rst_clears_pending got %b want 0", bus16.wr_pending);
    end
    bus16.n_we     = 1'b0;
    bus16.byte_sel = 1'b1;
    bus16.di       = 8'h66;
    tick();
    bus16.n_we = 1'b1;
    #1;
    checks++;
    if (bus16.addr_out !== 16'h6600) begin
      errors++;
      $display("FAIL rst_clears_stage got %h want 6600", bus16.addr_out);
    end
  endtask

  task automatic test_wide();
    logic [7:0] vals [3];
    vals[0] = 8'h01;
    vals[1] = 8'h02;
    vals[2] = 8'h03;
    bus24.dp_sel  = 3'd7;
    bus24.addr_dp = 1'b1;
    bus24.n_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus24.byte_sel = 2'(i);
      bus24.di       = vals[i];
      tick();
      if (i < 2) begin
        checks++;
        if (bus24.wr_pending !== 1'b1 || bus24.addr_out !== 24'h000000) begin
          errors++;
          $display("FAIL wide_stage[%0d] got pend %b addr %h want 1 000000",
                   i, bus24.wr_pending, bus24.addr_out);
        end
      end
    end
    bus24.n_we = 1'b1;
    #1;
    checks++;
    if (bus24.addr_out !== 24'h030201 || bus24.wr_pending !== 1'b0) begin
      errors++;
      $display("FAIL wide_commit got addr %h pend %b want 030201 0",
               bus24.addr_out, bus24.wr_pending);
    end
    bus24.dp_sel = 3'd6;
    #1;
    checks++;
    if (bus24.addr_out !== 24'h000000) begin
      errors++;
      $display("FAIL wide_other_ptr6 got %h want 000000", bus24.addr_out);
    end
    bus24.dp_sel   = 3'd7;
    bus24.n_we     = 1'b0;
    bus24.byte_sel = 2'd3;
    bus24.di       = 8'hFF;
    tick();
    bus24.n_we = 1'b1;
    #1;
    checks++;
    if (bus24.addr_out !== 24'h030201 || bus24.wr_pending !== 1'b0) begin
      errors++;
      $display("FAIL wide_oob_write got addr %h pend %b want 030201 0",
               bus24.addr_out, bus24.wr_pending);
    end
    bus24.n_oe_d   = 1'b0;
    bus24.byte_sel = 2'd2;
    #1;
    checks++;
    if (bus24.data_out !== 8'h03) begin
      errors++;
      $display("FAIL wide_read_b2 got %h want 03", bus24.data_out);
    end
    bus24.byte_sel = 2'd3;
    #1;
    checks++;
    if (bus24.data_out !== 8'h00) begin
      errors++;
      $display("FAIL wide_read_oob got %h want 00", bus24.data_out);
    end
    bus24.n_oe_d   = 1'b1;
    bus24.dp_sel   = 3'd5;
    bus24.n_we     = 1'b0;
    bus24.byte_sel = 2'd1;
    bus24.di       = 8'hAA;
    tick();
    bus24.byte_sel = 2'd2;
    bus24.di       = 8'hBB;
    tick();
    bus24.n_we = 1'b1;
    #1;
    checks++;
    if (bus24.addr_out !== 24'hBBAA00) begin
      errors++;
      $display("FAIL wide_partial got %h want BBAA00", bus24.addr_out);
    end
    bus24.dp_sel = 3'd4;
    bus24.n_we   = 1'b0;
    bus24.di     = 8'hCC;
    tick();
    bus24.n_we = 1'b1;
    #1;
    checks++;
    if (bus24.addr_out !== 24'hCC0000) begin
      errors++;
      $display("FAIL wide_stage_cleared got %h want CC0000", bus24.addr_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus16.di = 8'h00;  bus16.byte_sel = '0; bus16.ip_sel = '0; bus16.dp_sel = '0;
    bus16.addr_dp = 1'b0; bus16.n_oe_d = 1'b1; bus16.n_we = 1'b1;
    bus16.cnt = 1'b0;  bus16.cnt_dp = 1'b0;
    bus24.di = 8'h00;  bus24.byte_sel = '0; bus24.ip_sel = '0; bus24.dp_sel = '0;
    bus24.addr_dp = 1'b0; bus24.n_oe_d = 1'b1; bus24.n_we = 1'b1;
    bus24.cnt = 1'b0;  bus24.cnt_dp = 1'b0;
    tick();
    test_reset();
    test_atomic_write();
    test_ip_wrap();
    test_conflict();
    test_stage_with_count();
    test_reset_mid_write();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
